// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM states, parity codes
// and the baud divisor table.
package uart_tx_fifo_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   typedef enum logic [1:0] {
      PAR_NONE  = 2'b00,
      PAR_EVEN  = 2'b01,
      PAR_ODD   = 2'b10,
      PAR_NONE2 = 2'b11
   } parity_e;

   localparam int DIV_W         = 16;
   localparam int TICKS_PER_BIT = 16;

   // Each branch divides constants only, so the table folds to a mux of literals.
   function automatic logic [DIV_W-1:0] div_for(input logic [2:0] sel, input int clk_hz);
      case (sel)
         3'd0:    return DIV_W'((clk_hz + 8*300)    / (16*300));
         3'd1:    return DIV_W'((clk_hz + 8*1200)   / (16*1200));
         3'd2:    return DIV_W'((clk_hz + 8*4800)   / (16*4800));
         3'd3:    return DIV_W'((clk_hz + 8*9600)   / (16*9600));
         3'd4:    return DIV_W'((clk_hz + 8*19200)  / (16*19200));
         3'd5:    return DIV_W'((clk_hz + 8*38400)  / (16*38400));
         3'd6:    return DIV_W'((clk_hz + 8*57600)  / (16*57600));
         default: return DIV_W'((clk_hz + 8*115200) / (16*115200));
      endcase
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// 16x oversampling tick generator; restart re-phases the divider to a frame start.
module uart_baud_gen
   import uart_tx_fifo_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] baud_select,
   input  logic       restart,
   output logic       tick
);

   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] cnt_q, cnt_d;

   always_comb begin
      div   = div_for(baud_select, CLK_HZ);
      tick  = (cnt_q == div - DIV_W'(1));
      cnt_d = cnt_q + DIV_W'(1);
      if (restart || tick) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with write FIFO, 5..8 data bits, optional parity, 1/2 stop bits.
// Frames run back to back while Tx_EN is high and words are queued.
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] Tx_DATA,
   input  logic              Tx_WR,
   input  logic              Tx_EN,
   input  logic [2:0]        baud_select,
   input  logic [1:0]        parity_mode,
   input  logic              stop2,
   output logic              TxD,
   output logic              Tx_BUSY,
   output logic              Tx_FULL,
   output logic              Tx_EMPTY,
   output logic [CNT_W-1:0]  Tx_COUNT,
   output logic              Tx_OVF
);

   localparam int         AW       = $clog2(FIFO_DEPTH);
   localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

   // FIFO
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              full, empty, push, pop;
   logic [DATA_W-1:0] rd_data;

   // FSM / shifter
   tx_state_e         state_q;
   logic [DATA_W-1:0] shreg_q;
   logic [2:0]        bit_cnt_q;
   logic              stop_cnt_q, stop2_q, par_en_q, par_bit_q;
   logic [2:0]        baud_q;
   logic              txd_q, busy_q;
   logic [3:0]        tick_cnt_q, tick_cnt_d;
   logic              tick, bit_end, last_stop, frame_done;

   assign full    = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   assign rd_data = mem_q[rd_ptr_q];

   assign bit_end    = tick && (tick_cnt_q == 4'(TICKS_PER_BIT - 1));
   assign last_stop  = !stop2_q || stop_cnt_q;
   assign frame_done = (state_q == ST_STOP) && bit_end && last_stop;
   assign pop        = Tx_EN && !empty && ((state_q == ST_IDLE) || frame_done);
   // A pop frees a slot in the same cycle, so a full FIFO still accepts that write.
   assign push       = Tx_WR && (!full || pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
      ovf_d = Tx_WR && full && !pop;
      tick_cnt_d = tick_cnt_q;
      if (pop)       tick_cnt_d = '0;
      else if (tick) tick_cnt_d = tick_cnt_q + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= Tx_DATA;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         tick_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         tick_cnt_q <= tick_cnt_d;
      end
   end

   uart_baud_gen #(.CLK_HZ(CLK_HZ)) u_baud (
      .clk         (clk),
      .reset       (reset),
      .baud_select (baud_q),
      .restart     (pop),
      .tick        (tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         stop2_q    <= 1'b0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         baud_q     <= '0;
         txd_q      <= 1'b1;
         busy_q     <= 1'b0;
      end else if (pop) begin
         // Configuration is sampled only here, so mid-frame changes wait a frame.
         state_q    <= ST_START;
         shreg_q    <= rd_data;
         par_bit_q  <= (^rd_data) ^ (parity_mode == PAR_ODD);
         par_en_q   <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
         stop2_q    <= stop2;
         baud_q     <= baud_select;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         txd_q      <= 1'b0;
         busy_q     <= 1'b1;
      end else if (bit_end) begin
         case (state_q)
            ST_START: begin
               state_q   <= ST_DATA;
               txd_q     <= shreg_q[0];
               shreg_q   <= shreg_q >> 1;
               bit_cnt_q <= '0;
            end
            ST_DATA: begin
               if (bit_cnt_q == LAST_BIT) begin
                  state_q <= par_en_q ? ST_PARITY : ST_STOP;
                  txd_q   <= par_en_q ? par_bit_q : 1'b1;
               end else begin
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  txd_q     <= shreg_q[0];
                  shreg_q   <= shreg_q >> 1;
               end
            end
            ST_PARITY: begin
               state_q <= ST_STOP;
               txd_q   <= 1'b1;
            end
            ST_STOP: begin
               if (!last_stop) begin
                  stop_cnt_q <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
               txd_q <= 1'b1;
            end
            default: begin
               state_q <= ST_IDLE;
               txd_q   <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign TxD      = txd_q;
   assign Tx_BUSY  = busy_q;
   assign Tx_FULL  = full;
   assign Tx_EMPTY = empty;
   assign Tx_COUNT = count_q;
   assign Tx_OVF   = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 50 MHz / 115200 baud (432 clocks per bit).
module tb_uart_tx_fifo;

   localparam int BIT = 432;

   logic       clk;
   logic       reset;
   logic [7:0] Tx_DATA;
   logic       Tx_WR;
   logic       Tx_EN;
   logic [2:0] baud_select;
   logic [1:0] parity_mode;
   logic       stop2;
   logic       TxD;
   logic       Tx_BUSY;
   logic       Tx_FULL;
   logic       Tx_EMPTY;
   logic [2:0] Tx_COUNT;
   logic       Tx_OVF;

   int tests = 0;
   int fails = 0;

   uart_tx_fifo #(
      .CLK_HZ     (50_000_000),
      .DATA_W     (8),
      .FIFO_DEPTH (4),
      .CNT_W      (3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .Tx_DATA     (Tx_DATA),
      .Tx_WR       (Tx_WR),
      .Tx_EN       (Tx_EN),
      .baud_select (baud_select),
      .parity_mode (parity_mode),
      .stop2       (stop2),
      .TxD         (TxD),
      .Tx_BUSY     (Tx_BUSY),
      .Tx_FULL     (Tx_FULL),
      .Tx_EMPTY    (Tx_EMPTY),
      .Tx_COUNT    (Tx_COUNT),
      .Tx_OVF      (Tx_OVF)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      repeat (100000) @(posedge clk);
      $display("FAIL watchdog: observed no finish expected finish within 100000 cycles");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] f8n1(input logic [7:0] d);
      return {3'b001, d, 1'b0};
   endfunction

   task automatic wr(input logic [7:0] d);
      Tx_DATA = d;
      Tx_WR   = 1'b1;
      @(negedge clk);
      Tx_WR   = 1'b0;
   endtask

   task automatic wait_start(input int limit);
      bit ok = 1'b0;
      for (int i = 0; i < limit && !ok; i++) begin
         if (TxD === 1'b0) ok = 1'b1;
         else @(negedge clk);
      end
      chk("start_seen", 32'(ok), 32'd1);
   endtask

   // Entered on the negedge of the first start-bit cycle; checks the first and last
   // cycle of every bit, then the cycle right after the frame.
   task automatic run_frame(input logic [11:0] bits, input int nbits, input bit last,
                            input bit drop_en);
      for (int k = 0; k < nbits*BIT; k++) begin
         if (k != 0) @(negedge clk);
         if (drop_en && k == nbits*BIT/2) Tx_EN = 1'b0;
         if (k % BIT == 0 || k % BIT == BIT-1) chk("txd_bit", 32'(TxD), 32'(bits[k/BIT]));
         if (k == nbits*BIT-1) chk("busy_end", 32'(Tx_BUSY), 32'd1);
      end
      @(negedge clk);
      if (last) begin
         chk("busy_fall", 32'(Tx_BUSY), 32'd0);
         chk("idle_txd", 32'(TxD), 32'd1);
      end else begin
         chk("b2b_start", 32'(TxD), 32'd0);
         chk("b2b_busy", 32'(Tx_BUSY), 32'd1);
      end
   endtask

   initial begin
      reset       = 1'b0;
      Tx_DATA     = '0;
      Tx_WR       = 1'b0;
      Tx_EN       = 1'b0;
      baud_select = 3'b111;
      parity_mode = 2'b00;
      stop2       = 1'b0;

      // 1: reset held 100 ns
      repeat (4) begin
         @(negedge clk);
         chk("rst_txd", 32'(TxD), 32'd1);
         chk("rst_busy", 32'(Tx_BUSY), 32'd0);
         chk("rst_empty", 32'(Tx_EMPTY), 32'd1);
         chk("rst_count", 32'(Tx_COUNT), 32'd0);
      end
      chk("rst_full", 32'(Tx_FULL), 32'd0);
      chk("rst_ovf", 32'(Tx_OVF), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // 2: 8N1 single word
      Tx_EN = 1'b1;
      wr(8'hCB);
      chk("t2_count", 32'(Tx_COUNT), 32'd1);
      wait_start(20);
      run_frame(f8n1(8'hCB), 10, 1'b1, 1'b0);

      // 3a: even parity, two stop bits
      parity_mode = 2'b01;
      stop2       = 1'b1;
      wr(8'hCB);
      wait_start(20);
      run_frame({2'b11, 1'b1, 8'hCB, 1'b0}, 12, 1'b1, 1'b0);

      // 3b: odd parity, one stop bit; config scrambled mid-frame must not matter
      parity_mode = 2'b10;
      stop2       = 1'b0;
      wr(8'hCB);
      wait_start(20);
      parity_mode = 2'b00;
      stop2       = 1'b1;
      baud_select = 3'b000;
      run_frame({1'b0, 1'b1, 1'b0, 8'hCB, 1'b0}, 11, 1'b1, 1'b0);
      baud_select = 3'b111;
      stop2       = 1'b0;

      // 4: fill while disabled, overflow, then four back-to-back frames
      Tx_EN = 1'b0;
      Tx_WR = 1'b1;
      for (int i = 0; i < 5; i++) begin
         Tx_DATA = 8'(8'h11 * (i + 1));
         @(negedge clk);
         chk("t4_count", 32'(Tx_COUNT), 32'((i < 4) ? i + 1 : 4));
         chk("t4_full", 32'(Tx_FULL), 32'((i >= 3) ? 1 : 0));
         chk("t4_ovf", 32'(Tx_OVF), 32'((i == 4) ? 1 : 0));
      end
      Tx_WR = 1'b0;
      @(negedge clk);
      chk("t4_ovf_pulse", 32'(Tx_OVF), 32'd0);
      chk("t4_count_hold", 32'(Tx_COUNT), 32'd4);
      chk("t4_idle", 32'(TxD), 32'd1);
      Tx_EN = 1'b1;
      wait_start(10);
      chk("t4_c3", 32'(Tx_COUNT), 32'd3);
      run_frame(f8n1(8'h11), 10, 1'b0, 1'b0);
      chk("t4_c2", 32'(Tx_COUNT), 32'd2);
      run_frame(f8n1(8'h22), 10, 1'b0, 1'b0);
      chk("t4_c1", 32'(Tx_COUNT), 32'd1);
      run_frame(f8n1(8'h33), 10, 1'b0, 1'b0);
      chk("t4_c0", 32'(Tx_COUNT), 32'd0);
      chk("t4_empty", 32'(Tx_EMPTY), 32'd1);
      run_frame(f8n1(8'h44), 10, 1'b1, 1'b0);

      // 5: Tx_EN dropped halfway through frame 1 of 2 (second write coincides with pop)
      Tx_DATA = 8'hA5;
      Tx_WR   = 1'b1;
      @(negedge clk);
      Tx_DATA = 8'h3C;
      @(negedge clk);
      Tx_WR   = 1'b0;
      chk("t5_count", 32'(Tx_COUNT), 32'd1);
      wait_start(10);
      run_frame(f8n1(8'hA5), 10, 1'b1, 1'b1);
      repeat (10) begin
         repeat (100) @(negedge clk);
         chk("t5_txd_hold", 32'(TxD), 32'd1);
         chk("t5_count_hold", 32'(Tx_COUNT), 32'd1);
         chk("t5_busy", 32'(Tx_BUSY), 32'd0);
      end

      // 6: reset during DATA (first data bit of 8'h3C is 0)
      Tx_EN = 1'b1;
      wait_start(10);
      chk("t6_count0", 32'(Tx_COUNT), 32'd0);
      Tx_DATA = 8'h77;
      Tx_WR   = 1'b1;
      @(negedge clk);
      Tx_DATA = 8'h88;
      @(negedge clk);
      Tx_WR   = 1'b0;
      repeat (BIT + 200 - 2) @(negedge clk);
      chk("t6_pre_txd", 32'(TxD), 32'd0);
      chk("t6_pre_busy", 32'(Tx_BUSY), 32'd1);
      chk("t6_pre_count", 32'(Tx_COUNT), 32'd2);
      #5 reset = 1'b0;
      #1;
      chk("t6_rst_txd", 32'(TxD), 32'd1);
      chk("t6_rst_count", 32'(Tx_COUNT), 32'd0);
      chk("t6_rst_empty", 32'(Tx_EMPTY), 32'd1);
      chk("t6_rst_busy", 32'(Tx_BUSY), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (20) begin
         repeat (100) @(negedge clk);
         chk("t6_txd_idle", 32'(TxD), 32'd1);
         chk("t6_busy_idle", 32'(Tx_BUSY), 32'd0);
         chk("t6_count_idle", 32'(Tx_COUNT), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
